// File: rtl/serial_addsub.sv
// Chunk-serial adder/subtractor: processes CHUNK bits per cycle, LSB chunk first.
// Define SERIAL_ADDSUB_OVF_EN to enable the signed overflow flag (ovf is tied to 0 otherwise).
module serial_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             co,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid && ready; operands are
    // accepted only in IDLE and results are held in DONE until out_ready is seen.

    localparam int NCH   = WIDTH / CHUNK;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q, b_q, d_q;
    logic               sub_q, carry_q, co_q;
    logic [CNT_W-1:0]   cnt;
    logic [CHUNK-1:0]   a_ch, b_ch;
    logic [CHUNK:0]     sum;
    logic               last_chunk;
    logic               accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (last_chunk) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Operand chunk for the current counter value.
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign sum        = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    assign last_chunk = (cnt == CNT_W'(NCH - 1));

    // Subtraction runs as a + ~b + ~cin, so the final carry is the inverted borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            sub_q   <= sub;
            carry_q <= sub ? ~cin : cin;
            cnt     <= '0;
        end else if (state == BUSY) begin
            for (int i = 0; i < NCH; i++) begin
                if (cnt == CNT_W'(i)) d_q[i*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
            end
            carry_q <= sum[CHUNK];
            cnt     <= cnt + 1'b1;
            if (last_chunk) co_q <= sum[CHUNK] ^ sub_q;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q;
    logic ovf_bit;

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit position.
    assign ovf_bit = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ sum[CHUNK-1] ^ sum[CHUNK];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             ovf_q <= 1'b0;
        else if ((state == BUSY) && last_chunk) ovf_q <= ovf_bit;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign d         = d_q;
    assign co        = co_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 8/4 instance for directed cases, 32/8 and 32/32 instances against a model.
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 8-bit, 4-bit chunk instance
    logic        in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        in_ready8, out_valid8, co8, ovf8;
    logic [7:0]  d8;
    logic [1:0]  st8;

    // 32-bit instances share inputs
    logic        in_valid32 = 1'b0, out_ready32 = 1'b0, cin32 = 1'b0, sub32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        in_ready_c8, out_valid_c8, co_c8, ovf_c8;
    logic        in_ready_c32, out_valid_c32, co_c32, ovf_c32;
    logic [31:0] d_c8, d_c32;
    logic [1:0]  st_c8, st_c32;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .CHUNK(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .d(d8), .co(co8), .ovf(ovf8), .state_dbg(st8)
    );

    serial_addsub #(.WIDTH(32), .CHUNK(8)) u_c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready_c8),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32), .out_valid(out_valid_c8),
        .out_ready(out_ready32), .d(d_c8), .co(co_c8), .ovf(ovf_c8), .state_dbg(st_c8)
    );

    serial_addsub #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready_c32),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32), .out_valid(out_valid_c32),
        .out_ready(out_ready32), .d(d_c32), .co(co_c32), .ovf(ovf_c32), .state_dbg(st_c32)
    );

    // ---------------- driver tasks ----------------
    task automatic drive_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                             input logic tsub, input bit scramble, output int lat);
        a8 = ta; b8 = tb; cin8 = tcin; sub8 = tsub; in_valid8 = 1'b1;
        @(posedge clk); #1;
        if (scramble) begin
            a8 = 8'hFF; b8 = 8'hA5; cin8 = ~tcin; sub8 = ~tsub;
        end else begin
            in_valid8 = 1'b0;
        end
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid8 = 1'b0;
    endtask

    task automatic consume8();
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic drive_op32(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                              input logic tsub, output int lat_c8, output int lat_c32);
        a32 = ta; b32 = tb; cin32 = tcin; sub32 = tsub; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        lat_c8 = -1; lat_c32 = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (out_valid_c8 && lat_c8 < 0)   lat_c8  = c;
            if (out_valid_c32 && lat_c32 < 0) lat_c32 = c;
            if (lat_c8 >= 0 && lat_c32 >= 0) break;
        end
    endtask

    task automatic consume32();
        out_ready32 = 1'b1;
        @(posedge clk); #1;
        out_ready32 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if ({d8, co8, ovf8, out_valid8} !== 11'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", {d8, co8, ovf8, out_valid8});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready8 !== 1'b1 || st8 !== S_IDLE) begin
            n_fail++; $display("FAIL reset_idle: got in_ready=%b state=%0d expected 1/0", in_ready8, st8);
        end
    endtask

    task automatic test_vectors();
        // a, b, cin, sub, d, co, ovf (ovf as computed with the flag enabled)
        logic [7:0] va[7]  = '{8'd4,  8'd10, 8'd0,  8'd200, 8'd100, 8'd128, 8'd255};
        logic [7:0] vb[7]  = '{8'd10, 8'd4,  8'd16, 8'd100, 8'd100, 8'd1,   8'd0};
        logic       vc[7]  = '{1'b0,  1'b1,  1'b0,  1'b0,   1'b0,   1'b0,   1'b1};
        logic       vs[7]  = '{1'b0,  1'b1,  1'b1,  1'b0,   1'b0,   1'b1,   1'b0};
        logic [7:0] vd[7]  = '{8'd14, 8'd5,  8'd240,8'd44,  8'd200, 8'd127, 8'd0};
        logic       vco[7] = '{1'b0,  1'b0,  1'b1,  1'b1,   1'b0,   1'b0,   1'b1};
        logic       vov[7] = '{1'b0,  1'b0,  1'b0,  1'b0,   1'b1,   1'b1,   1'b0};
        int lat;
        for (int i = 0; i < 7; i++) begin
            drive_op8(va[i], vb[i], vc[i], vs[i], (i == 0), lat);
            n_tests++;
            if (lat !== 2) begin
                n_fail++; $display("FAIL vec%0d_latency: got %0d expected 2", i, lat);
            end
            n_tests++;
            if (d8 !== vd[i] || co8 !== vco[i]) begin
                n_fail++; $display("FAIL vec%0d_result: got d=%0d co=%b expected d=%0d co=%b", i, d8, co8, vd[i], vco[i]);
            end
            n_tests++;
            if (ovf8 !== (vov[i] & OVF_EN)) begin
                n_fail++; $display("FAIL vec%0d_ovf: got %b expected %b", i, ovf8, vov[i] & OVF_EN);
            end
            consume8();
        end
    endtask

    task automatic test_stall();
        int lat;
        drive_op8(8'd7, 8'd8, 1'b0, 1'b0, 1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || d8 !== 8'd15 || co8 !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d: got v=%b r=%b d=%0d co=%b expected 1 0 15 0", c, out_valid8, in_ready8, d8, co8);
            end
            @(posedge clk); #1;
        end
        consume8();
        n_tests++;
        if (st8 !== S_IDLE || out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: got state=%0d v=%b r=%b expected 0 0 1", st8, out_valid8, in_ready8);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        drive_op8(8'd1, 8'd2, 1'b0, 1'b0, 1'b0, lat);
        a8 = 8'd50; b8 = 8'd25; cin8 = 1'b1; sub8 = 1'b1; in_valid8 = 1'b1;
        consume8();
        n_tests++;
        if (st8 !== S_IDLE || in_ready8 !== 1'b1) begin
            n_fail++; $display("FAIL b2b_no_bypass: got state=%0d r=%b expected 0 1", st8, in_ready8);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n_tests++;
        if (st8 !== S_BUSY) begin
            n_fail++; $display("FAIL b2b_accept: got state=%0d expected 1", st8);
        end
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat !== 2 || d8 !== 8'd24 || co8 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_result: got lat=%0d d=%0d co=%b expected 2 24 0", lat, d8, co8);
        end
        consume8();
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        bit seen;
        a8 = 8'd50; b8 = 8'd60; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (st8 !== S_BUSY) begin
            n_fail++; $display("FAIL abort_busy: got state=%0d expected 1", st8);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({d8, co8, ovf8, out_valid8} !== 11'd0 || st8 !== S_IDLE) begin
            n_fail++; $display("FAIL abort_outputs: got %h state=%0d expected 0 0", {d8, co8, ovf8, out_valid8}, st8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid8) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_result: got out_valid seen=%b expected 0", seen);
        end
        drive_op8(8'd189, 8'd20, 1'b0, 1'b0, 1'b0, lat);
        n_tests++;
        if (lat !== 2 || d8 !== 8'd209 || co8 !== 1'b0 || ovf8 !== 1'b0) begin
            n_fail++; $display("FAIL abort_next_op: got lat=%0d d=%0d co=%b ovf=%b expected 2 209 0 0", lat, d8, co8, ovf8);
        end
        consume8();
    endtask

    task automatic test_random32();
        logic [31:0] ta, tb, exp_d;
        logic        tcin, tsub, exp_co;
        logic [32:0] full;
        int lat_c8, lat_c32;
        for (int i = 0; i < 24; i++) begin
            ta = $urandom; tb = $urandom;
            tcin = 1'($urandom_range(0, 1));
            tsub = 1'(i % 2);
            if (i == 0) begin ta = 32'd0; tb = 32'hFFFF_FFFF; tcin = 1'b1; tsub = 1'b0; end
            if (i == 1) begin ta = 32'd0; tb = 32'd0;         tcin = 1'b1; tsub = 1'b1; end
            if (tsub) full = {1'b0, ta} - {1'b0, tb} - {32'd0, tcin};
            else      full = {1'b0, ta} + {1'b0, tb} + {32'd0, tcin};
            exp_d = full[31:0]; exp_co = full[32];
            drive_op32(ta, tb, tcin, tsub, lat_c8, lat_c32);
            n_tests++;
            if (d_c8 !== exp_d || co_c8 !== exp_co || lat_c8 !== 4) begin
                n_fail++; $display("FAIL rand%0d_chunk8: got d=%h co=%b lat=%0d expected d=%h co=%b lat=4", i, d_c8, co_c8, lat_c8, exp_d, exp_co);
            end
            n_tests++;
            if (d_c32 !== exp_d || co_c32 !== exp_co || lat_c32 !== 1) begin
                n_fail++; $display("FAIL rand%0d_chunk32: got d=%h co=%b lat=%0d expected d=%h co=%b lat=1", i, d_c32, co_c32, lat_c32, exp_d, exp_co);
            end
            consume32();
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_stall();
        test_back_to_back();
        test_reset_mid_busy();
        test_random32();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
